// File: rtl/draw_fb_writer.sv
// Horizontal line pixel writer: takes x positions from a line drawer, clips to the
// framebuffer, queues addresses in a small FIFO and issues framebuffer writes.
module draw_fb_writer #(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDRW  = 19,
    parameter int COLRW  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [CORDW-1:0] y,
    input  logic        [COLRW-1:0] colr,
    input  logic signed [CORDW-1:0] x,
    input  logic                    drawing,
    input  logic                    line_done,
    output logic                    oe,
    output logic                    fb_we,
    output logic        [ADDRW-1:0] fb_addr,
    output logic        [COLRW-1:0] fb_colr,
    input  logic                    fb_ready,
    output logic                    busy,
    output logic                    done,
    output logic        [CORDW-1:0] clip_cnt
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic        [PTRW:0]    FULL     = (PTRW+1)'(DEPTH);
    localparam logic        [PTRW:0]    ONE      = (PTRW+1)'(1);
    localparam logic signed [CORDW-1:0] WIDTH_C  = CORDW'(WIDTH);
    localparam logic signed [CORDW-1:0] HEIGHT_C = CORDW'(HEIGHT);
    localparam logic        [ADDRW-1:0] WIDTH_A  = ADDRW'(WIDTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t state, state_next;

    logic [ADDRW-1:0] row_base;
    logic             row_on;
    logic [COLRW-1:0] colr_r;

    logic [ADDRW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr, rd_ptr;
    logic [PTRW:0]    count;

    logic x_on, accept, push, pop, clip, start_line;
    logic [ADDRW-1:0] entry;

    assign start_line = (state == IDLE) && start;
    assign x_on       = !x[CORDW-1] && (x < WIDTH_C);
    assign accept     = drawing && oe;
    assign push       = accept && x_on && row_on;
    assign clip       = accept && !(x_on && row_on);
    assign pop        = fb_we && fb_ready;
    assign entry      = row_base + ADDRW'(x);

    assign oe      = (state == ACTIVE) && (count < FULL);
    assign fb_we   = (count != '0);
    assign fb_addr = mem[rd_ptr];
    assign fb_colr = colr_r;
    assign busy    = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACTIVE;
            ACTIVE:  if (line_done) state_next = DRAIN;
            // Leave as soon as the final queued write is being accepted.
            DRAIN:   if ((count == '0) || ((count == ONE) && pop)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DRAIN) && (state_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
            row_on   <= 1'b0;
            colr_r   <= '0;
            clip_cnt <= '0;
        end else if (start_line) begin
            row_base <= ADDRW'(y) * WIDTH_A;
            row_on   <= !y[CORDW-1] && (y < HEIGHT_C);
            colr_r   <= colr;
            clip_cnt <= '0;
        end else if (clip && (clip_cnt != '1)) begin
            clip_cnt <= clip_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; an empty count masks stale entries, and
    // leaving it unreset lets it map onto plain RAM/register cells.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

endmodule

// File: tb/tb_draw_fb_writer.sv
// Directed bench for draw_fb_writer: stimulus pushes expected writes into a
// scoreboard queue, an independent monitor compares every framebuffer write.
module tb_draw_fb_writer;

    localparam int CORDW  = 16;
    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int ADDRW  = 19;
    localparam int COLRW  = 4;
    localparam int DEPTH  = 4;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, drawing = 1'b0, line_done = 1'b0, fb_ready = 1'b1;
    logic signed [CORDW-1:0] y = '0, x = '0;
    logic        [COLRW-1:0] colr = '0;
    logic oe, fb_we, busy, done;
    logic [ADDRW-1:0] fb_addr;
    logic [COLRW-1:0] fb_colr;
    logic [CORDW-1:0] clip_cnt;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [COLRW-1:0] colr;
    } wr_t;

    wr_t sb[$];
    int vectors = 0, errors = 0;
    int cyc = 0, last_wr_cyc = 0, done_cnt = 0, done_start = 0, line_writes = 0;
    int ce, blk;

    draw_fb_writer #(
        .CORDW(CORDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .ADDRW(ADDRW), .COLRW(COLRW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y), .colr(colr), .x(x),
        .drawing(drawing), .line_done(line_done), .oe(oe), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_colr(fb_colr), .fb_ready(fb_ready),
        .busy(busy), .done(done), .clip_cnt(clip_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the scoreboard head, held while stalled.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            check("write_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                check("fb_addr", fb_addr, sb[0].addr);
                check("fb_colr", fb_colr, sb[0].colr);
                if (fb_ready === 1'b1) begin
                    void'(sb.pop_front());
                    last_wr_cyc = cyc;
                    line_writes++;
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic draw_line(input int yy, input int cc, input int x0, input int x1,
                             output int clip_exp, output int blocked);
        int  xi = x0;
        int  acc = 0;
        int  budget = 0;
        bit  first = 1'b1;
        wr_t e;
        clip_exp    = 0;
        blocked     = -1;
        line_writes = 0;
        done_start  = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; y = CORDW'(yy); colr = COLRW'(cc);
        @(posedge clk); #1;
        start = 1'b0;
        while (xi <= x1 && budget < 200) begin
            x = CORDW'(xi); drawing = 1'b1; line_done = 1'b0;
            @(negedge clk);
            if (first) begin
                check("busy_in_line", busy, 1);
                first = 1'b0;
            end
            if (oe === 1'b1) begin
                if (xi >= 0 && xi < WIDTH && yy >= 0 && yy < HEIGHT) begin
                    e.addr = ADDRW'(yy * WIDTH + xi);
                    e.colr = COLRW'(cc);
                    sb.push_back(e);
                end else begin
                    clip_exp++;
                end
                if (xi == x1) line_done = 1'b1;
                acc++;
                xi++;
            end else if (blocked < 0) begin
                blocked = acc;
            end
            @(posedge clk); #1;
            budget++;
        end
        drawing = 1'b0; line_done = 1'b0;
        check("pixels_accepted", acc, x1 - x0 + 1);
    endtask

    task automatic finish_line(input int exp_clip, input int writes_exp);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        if (writes_exp > 0) check("done_latency", cyc - last_wr_cyc, 1);
        check("busy_at_done", busy, 0);
        check("sb_empty", sb.size(), 0);
        check("write_count", line_writes, writes_exp);
        check("clip_cnt", clip_cnt, exp_clip);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("done_count", done_cnt - done_start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        wr_t e;
        #2 rst_n = 1'b0;
        #1;
        check("rst_fb_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oe", oe, 0);
        check("rst_clip", clip_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // y=2, x=3..6: addresses 1283..1286
        draw_line(2, 5, 3, 6, ce, blk);
        finish_line(ce, 4);
        check("clip_line1", ce, 0);

        // y=0, x=-2..2: two clipped, writes 0,1,2
        draw_line(0, 1, -2, 2, ce, blk);
        finish_line(ce, 3);
        check("clip_line2", ce, 2);

        // y=480 off-screen: everything clipped
        draw_line(480, 2, 0, 9, ce, blk);
        finish_line(ce, 0);
        check("clip_line3", ce, 10);

        // Backpressure: fb_ready low long enough to fill the FIFO
        fb_ready = 1'b0;
        fork
            draw_line(7, 9, 100, 107, ce, blk);
            begin
                repeat (12) @(posedge clk);
                #1 fb_ready = 1'b1;
            end
        join
        check("oe_block_after", blk, DEPTH);
        finish_line(ce, 8);

        // Single bottom-right pixel: address 307199
        draw_line(479, 15, 639, 639, ce, blk);
        finish_line(ce, 1);

        // Reset with three queued pixels
        fb_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; y = CORDW'(1); colr = COLRW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = CORDW'(i); drawing = 1'b1;
            @(negedge clk);
            check("oe_pre_reset", oe, 1);
            e.addr = ADDRW'(640 + i);
            e.colr = COLRW'(3);
            sb.push_back(e);
            @(posedge clk); #1;
        end
        drawing = 1'b0;
        check("fb_we_pre_reset", fb_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_fb_we", fb_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_oe", oe, 0);
        check("midrst_done", done, 0);
        sb.delete();
        fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        draw_line(1, 3, 10, 11, ce, blk);
        finish_line(ce, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/draw_fb_writer.md
DRAW_FB_WRITER -- requirements
Module: draw_fb_writer

Interface
REQ-001 SHALL have parameter CORDW, default 16, signed coordinate width of x and y.
REQ-002 SHALL have parameter WIDTH, default 640, framebuffer width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 480, framebuffer height in pixels.
REQ-004 SHALL have parameter ADDRW, default 19, framebuffer address width.
REQ-005 SHALL have parameter COLRW, default 4, colour width.
REQ-006 SHALL have parameter DEPTH, default 4, pixel FIFO depth (power of two, >=2).
REQ-007 Port clk  input  1  clock; the block has one clock.
REQ-008 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 Port start  input  1  begin new line; latch y and colr.
REQ-010 Port y  input  CORDW signed  row of line.
REQ-011 Port colr  input  COLRW  line colour.
REQ-012 Port x  input  CORDW signed  drawer position.
REQ-013 Port drawing  input  1  x valid this cycle.
REQ-014 Port line_done  input  1  drawer finished (one-cycle pulse).
REQ-015 Port oe  output  1  output enable (backpressure) to drawer.
REQ-016 Port fb_we  output  1  framebuffer write request.
REQ-017 Port fb_addr  output  ADDRW  framebuffer write address.
REQ-018 Port fb_colr  output  COLRW  framebuffer write data.
REQ-019 Port fb_ready  input  1  framebuffer accepts write this cycle.
REQ-020 Port busy  output  1  line request in progress.
REQ-021 Port done  output  1  all pixels of line written (one-cycle pulse).
REQ-022 Port clip_cnt  output  CORDW  pixels dropped by clipping in current/last line.

Function
REQ-023 SHALL implement states IDLE, ACTIVE, DRAIN.
REQ-024 IDLE: on start, SHALL latch y, colr, row_base = y*WIDTH (ADDRW bits), clear clip_cnt, set busy=1, go ACTIVE next cycle.
REQ-025 start SHALL be ignored in ACTIVE and DRAIN; line_done and drawing SHALL be ignored in IDLE.
REQ-026 oe SHALL be combinational: 1 iff state==ACTIVE and FIFO count < DEPTH.
REQ-027 Pixel pushed when drawing=1 and oe=1 and 0<=x<WIDTH and 0<=latched y<HEIGHT; entry = row_base + x.
REQ-028 drawing=1, oe=1 with x or y off-screen: pixel SHALL be dropped, clip_cnt incremented (saturating at all-ones).
REQ-029 fb_we SHALL equal FIFO not empty; fb_addr SHALL be head entry; fb_colr SHALL be latched colour.
REQ-030 FIFO pop SHALL occur only when fb_we=1 and fb_ready=1; fb_addr SHALL hold stable while fb_we=1 and fb_ready=0.
REQ-031 Simultaneous push and pop SHALL leave count unchanged and preserve order; no write lost or duplicated.
REQ-032 ACTIVE: on line_done (pixel in same cycle still processed) SHALL go DRAIN.
REQ-033 DRAIN: when FIFO empty, or last pop occurring this cycle, SHALL go IDLE, busy=0, done=1 for exactly one cycle.
REQ-034 Writes SHALL issue in x order; pixel-to-fb_we latency from push = 1 cycle when FIFO empty.

Reset
REQ-035 On rst_n=0 (any time, asynchronously) SHALL enter IDLE with busy=0, done=0, fb_we=0 (FIFO emptied), oe=0, clip_cnt=0.
REQ-036 Reset mid-line SHALL discard all queued pixels; no write after rst_n asserts.
REQ-037 After rst_n deasserts, first start SHALL be accepted on next clk edge.

Verification
REQ-038 y=2, colr=5, x=3..6 drawing each cycle, fb_ready=1 -> writes addr 1283,1284,1285,1286 colr 5, done one cycle after last write, clip_cnt=0.
REQ-039 x=-2..2, y=0, fb_ready=1 -> writes addr 0,1,2 only, clip_cnt=2, done asserted once.
REQ-040 y=480 (off-screen), x=0..9 -> no fb_we, clip_cnt=10, done after line_done.
REQ-041 fb_ready=0 for 10 cycles, 8-pixel line -> oe drops after 4 pushes, fb_addr stable, all 8 writes in order once fb_ready=1, none lost.
REQ-042 Single-pixel line x0=x1=639, y=479 -> one write addr 307199, done pulse.
REQ-043 rst_n low with 3 queued pixels -> fb_we=0 immediately, busy=0, no further writes; subsequent start works normally.
